des_key_sched: RTL
==================

DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 key  input  64  DES key; DES bit n (1..64) maps to key[65-n], so key[64] is DES bit 1; parity bits are ignored.
REQ-004 key_load  input  1  request; samples key and mode when the block is idle.
REQ-005 mode  input  1  1 = decrypt order (K16..K1); 0 = encrypt order (K1..K16).
REQ-006 busy  output  1  high from the accepted load until the last subkey transfers.
REQ-007 subkey  output  48  current round subkey; DES bit n maps to subkey[49-n].
REQ-008 subkey_valid  output  1  subkey and round are valid.
REQ-009 subkey_ready  input  1  consumer accepts subkey; transfer = subkey_valid & subkey_ready.
REQ-010 round  output  4  index of the DES round the subkey belongs to, minus 1 (K1=0 ... K16=15).
REQ-011 done  output  1  one-cycle pulse in the cycle of the 16th transfer.

Function
REQ-012 FSM states: IDLE, RUN.
- IDLE->RUN on key_load.
- RUN->IDLE on the 16th transfer.
REQ-013 On load, C/D registers get PC-1(key): C = DES PC-1 output bits 1-28, D = bits 29-56.
REQ-014 Encrypt mode, step i=1..16: C,D rotate left by S[i], where S = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- The subkey emitted for step i is PC-2 of the rotated C,D.
REQ-015 Decrypt mode, step 1: C,D are not rotated.
- Step j=2..16: C,D rotate right by S[18-j].
- Step j emits PC-2(C,D) as K(17-j).
REQ-016 Latency: key_load accepted in cycle t -> subkey_valid high in cycle t+1 carrying the first subkey.
REQ-017 After each transfer, the next subkey appears in the following cycle, giving one subkey per cycle under continuous ready.
REQ-018 While subkey_valid is high and subkey_ready is low, subkey, round and internal C/D are held stable.
REQ-019 key_load while busy is ignored; the key sample and mode are unchanged.
REQ-020 key_load in the same cycle as the final transfer is ignored; a new load is accepted only in IDLE.
REQ-021 round counts 0..15 in encrypt mode and 15..0 in decrypt mode; no wrap beyond the 16th subkey.
REQ-022 After the sequence completes, C/D equal the post-PC-1 values (total rotation 28).
REQ-023 In IDLE: subkey_valid=0 and done=0; subkey holds its last value.

Reset
REQ-024 reset forces IDLE and clears everything below, including mid-sequence and with valid pending:
- outputs busy, subkey_valid, done, round, subkey = 0.
- internal C/D = 0 and the step counter = 0.
REQ-025 reset overrides key_load in the same cycle.
REQ-026 The first load is accepted in the cycle after reset deasserts.

Structure
REQ-027 Shared package des_pkg holds:
- the PC-1 and PC-2 tables
- the shift schedule S
- the FSM state type
- subkey width and round-count constants.
REQ-028 Sub-module des_pc2 is purely combinational: 56-bit C||D in, 48-bit subkey out.
REQ-029 All other logic is single-clock, with no latches.

Verification
REQ-030 Key 0x133457799BBCDFF1, mode=0, ready=1 -> first subkey 0x1B02EFFC7072 (round 0) one cycle after load; 16th subkey 0xCB3D8B0E17F5 (round 15) with done pulse.
REQ-031 Same key, mode=1 -> first subkey 0xCB3D8B0E17F5 (round 15); last subkey 0x1B02EFFC7072 (round 0); 16 consecutive valid cycles.
REQ-032 Random ready deassertion (e.g. ready low for 3 cycles after the 5th subkey) -> outputs held, no subkey skipped or repeated, done after exactly 16 transfers.
REQ-033 key_load pulsed with a different key at step 8 -> ignored; sequence completes with the original key's subkeys.
REQ-034 reset asserted at step 10 with valid high -> next cycle IDLE with all outputs 0; a fresh load then yields a correct full sequence.
REQ-035 Key 0x0000000000000000, both modes -> all 16 subkeys 0x000000000000; key 0x0101010101010101 gives the same result (parity ignored).

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: permutation tables, shift schedule,
// FSM state type and the width/round constants used across the block.
package des_pkg;

  localparam int unsigned KEY_W    = 64;
  localparam int unsigned CD_W     = 56;
  localparam int unsigned HALF_W   = 28;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned ROUNDS   = 16;
  localparam int unsigned ROUND_W  = 4;

  typedef enum logic {IDLE, RUN} state_t;

  // Entries are 1-based DES bit numbers of the source vector.
  localparam int unsigned PC1 [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int unsigned SHIFTS [ROUNDS] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  function automatic logic [CD_W:1] pc1(input logic [KEY_W:1] k);
    logic [CD_W:1] r;
    r = '0;
    for (int unsigned n = 1; n <= CD_W; n++)
      r[6'(CD_W + 1 - n)] = k[7'(KEY_W + 1 - PC1[n-1])];
    return r;
  endfunction

  // DES bit 1 sits at the MSB of each half, so a DES left rotate is a vector left rotate.
  function automatic logic [CD_W:1] rot_cd(input logic [CD_W:1] v, input logic right,
                                           input int unsigned amt);
    logic [HALF_W:1] c, d;
    c = v[CD_W:HALF_W+1];
    d = v[HALF_W:1];
    if (right) begin
      c = (amt == 2) ? {c[2:1], c[HALF_W:3]} : {c[1], c[HALF_W:2]};
      d = (amt == 2) ? {d[2:1], d[HALF_W:3]} : {d[1], d[HALF_W:2]};
    end else begin
      c = (amt == 2) ? {c[HALF_W-2:1], c[HALF_W:HALF_W-1]} : {c[HALF_W-1:1], c[HALF_W]};
      d = (amt == 2) ? {d[HALF_W-2:1], d[HALF_W:HALF_W-1]} : {d[HALF_W-1:1], d[HALF_W]};
    end
    return {c, d};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational DES PC-2: compresses the 56-bit C||D pair into a 48-bit subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W:1]     cd,
  output logic [SUBKEY_W:1] subkey
);

  always_comb begin
    subkey = '0;
    for (int unsigned n = 1; n <= SUBKEY_W; n++)
      subkey[6'(SUBKEY_W + 1 - n)] = cd[6'(CD_W + 1 - PC2[n-1])];
  end

endmodule

// File: rtl/des_key_sched.sv
// DES key schedule: streams the 16 round subkeys in encrypt or decrypt order
// over a valid/ready handshake, one subkey per transfer.
module des_key_sched
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [KEY_W:1]      key,
  input  logic                key_load,
  input  logic                mode,
  output logic                busy,
  output logic [SUBKEY_W:1]   subkey,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [ROUND_W-1:0]  round,
  output logic                done
);

  state_t              state;
  logic                dec;
  logic [ROUND_W-1:0]  cnt;
  logic [CD_W:1]       cd, cd_nxt;
  logic [SUBKEY_W:1]   pc2_out;
  logic                xfer, last;

  assign xfer = subkey_valid & subkey_ready;
  assign last = (cnt == ROUND_W'(ROUNDS - 1));
  assign done = xfer & last;

  // Decrypt also rotates on the final transfer so C/D end back at the PC-1 value.
  always_comb begin
    cd_nxt = cd;
    if (state == IDLE)
      cd_nxt = mode ? pc1(key) : rot_cd(pc1(key), 1'b0, SHIFTS[0]);
    else if (xfer) begin
      if (dec)
        cd_nxt = rot_cd(cd, 1'b1, SHIFTS[ROUND_W'(ROUNDS - 1) - cnt]);
      else if (!last)
        cd_nxt = rot_cd(cd, 1'b0, SHIFTS[cnt + ROUND_W'(1)]);
    end
  end

  des_pc2 u_pc2 (
    .cd     (cd_nxt),
    .subkey (pc2_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dec          <= 1'b0;
      cnt          <= '0;
      cd           <= '0;
      busy         <= 1'b0;
      subkey_valid <= 1'b0;
      subkey       <= '0;
      round        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_load) begin
            state        <= RUN;
            dec          <= mode;
            cnt          <= '0;
            cd           <= cd_nxt;
            subkey       <= pc2_out;
            round        <= mode ? ROUND_W'(ROUNDS - 1) : '0;
            busy         <= 1'b1;
            subkey_valid <= 1'b1;
          end
        end
        RUN: begin
          if (xfer) begin
            cd <= cd_nxt;
            if (last) begin
              state        <= IDLE;
              cnt          <= '0;
              busy         <= 1'b0;
              subkey_valid <= 1'b0;
            end else begin
              cnt    <= cnt + ROUND_W'(1);
              subkey <= pc2_out;
              round  <= dec ? round - ROUND_W'(1) : round + ROUND_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
